// File: rtl/top.sv
// Direct-mapped instruction cache with a line fill buffer and an internal bus
// interface model that returns a fixed 4-beat line a set number of cycles after a request.
//
// state     | meaning
// IDLE      | accepting fetches; hits answered from the arrays
// MISS_REQ  | line request raised, waiting for the bus acknowledge
// MISS_FILL | collecting beats 0..3 into the LFB, forwarding the wanted beat
// REFILL    | copying the LFB line and tag into the set, setting valid
module top #(
  parameter int NSETS       = 64,
  parameter int BIU_ACK_DLY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ifu_icu_req_ic1,
  input  logic [31:3] ifu_icu_addr_ic1,
  output logic        icu_ifu_ack_ic1,
  output logic        icu_ifu_data_valid_ic2,
  output logic [63:0] icu_ifu_data_ic2
);

  localparam int IDXW = $clog2(NSETS);
  localparam int TAGW = 27 - IDXW;

  typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_FILL, REFILL} state_t;
  typedef enum logic [1:0] {B_IDLE, B_WAIT, B_BEAT} biu_st_t;

  state_t   state;
  biu_st_t  biu_st;
  logic [2:0] biu_cnt;
  logic [1:0] biu_beat;

  logic        icu_biu_req;
  logic        biu_icu_ack;
  logic [63:0] biu_icu_data;
  logic        biu_icu_data_valid;
  logic        biu_icu_data_last;

  logic [63:0]     data_mem [NSETS][4];
  logic [TAGW-1:0] tag_mem  [NSETS];
  logic [NSETS-1:0] valid_q;
  logic [63:0]     lfb [4];

  logic            ic2_pend;
  logic [IDXW-1:0] miss_idx;
  logic [TAGW-1:0] miss_tag;
  logic [1:0]      miss_off;
  logic [1:0]      fill_cnt;
  logic            hit_r;
  logic            fwd_r;
  logic [63:0]     hit_data;

  logic [IDXW-1:0] idx1;
  logic [TAGW-1:0] tag1;
  logic [1:0]      off1;
  logic            hit1;

  // Bus interface model: down-counter to the acknowledge, then four beats in order.
  always_ff @(posedge clk) begin
    if (resetn) begin
      biu_st   <= B_IDLE;
      biu_cnt  <= '0;
      biu_beat <= '0;
    end else begin
      case (biu_st)
        B_IDLE: if (icu_biu_req) begin
          biu_st  <= B_WAIT;
          biu_cnt <= 3'(BIU_ACK_DLY - 1);
        end
        B_WAIT: if (biu_cnt == 3'd0) begin
          biu_st   <= B_BEAT;
          biu_beat <= 2'd0;
        end else begin
          biu_cnt <= biu_cnt - 3'd1;
        end
        B_BEAT: begin
          biu_beat <= biu_beat + 2'd1;
          if (biu_beat == 2'd3) biu_st <= B_IDLE;
        end
        default: biu_st <= B_IDLE;
      endcase
    end
  end

  assign biu_icu_ack        = (biu_st == B_WAIT) && (biu_cnt == 3'd0);
  assign biu_icu_data_valid = (biu_st == B_BEAT);
  assign biu_icu_data_last  = biu_icu_data_valid && (biu_beat == 2'd3);
  assign biu_icu_data       = biu_icu_data_valid ?
                              64'hBBBBBBBBBBBBBBBB + 64'(biu_beat) * 64'h1111111111111111 : 64'h0;

  // Tag lookup happens on the ic1 address so the hit result can be registered into ic2.
  assign idx1 = ifu_icu_addr_ic1[4+IDXW:5];
  assign tag1 = ifu_icu_addr_ic1[31:5+IDXW];
  assign off1 = ifu_icu_addr_ic1[4:3];
  assign hit1 = valid_q[idx1] && (tag_mem[idx1] == tag1);

  assign icu_ifu_ack_ic1 = !resetn && ifu_icu_req_ic1 && (state == IDLE) && !ic2_pend;

  always_ff @(posedge clk) begin
    if (resetn) begin
      state       <= IDLE;
      valid_q     <= '0;
      ic2_pend    <= 1'b0;
      icu_biu_req <= 1'b0;
      miss_idx    <= '0;
      miss_tag    <= '0;
      miss_off    <= '0;
      fill_cnt    <= '0;
      hit_r       <= 1'b0;
      fwd_r       <= 1'b0;
      hit_data    <= '0;
      for (int k = 0; k < 4; k++) lfb[k] <= '0;
    end else begin
      hit_r    <= 1'b0;
      fwd_r    <= 1'b0;
      ic2_pend <= icu_ifu_ack_ic1;
      case (state)
        IDLE: if (icu_ifu_ack_ic1) begin
          if (hit1) begin
            hit_r    <= 1'b1;
            hit_data <= data_mem[idx1][off1];
          end else begin
            state       <= MISS_REQ;
            icu_biu_req <= 1'b1;
            miss_idx    <= idx1;
            miss_tag    <= tag1;
            miss_off    <= off1;
            fill_cnt    <= 2'd0;
          end
        end
        MISS_REQ: if (biu_icu_ack) begin
          icu_biu_req <= 1'b0;
          state       <= MISS_FILL;
        end
        MISS_FILL: if (biu_icu_data_valid) begin
          lfb[fill_cnt] <= biu_icu_data;
          fill_cnt      <= fill_cnt + 2'd1;
          if (fill_cnt == miss_off) fwd_r <= 1'b1;
          if (biu_icu_data_last) state <= REFILL;
        end
        REFILL: begin
          valid_q[miss_idx] <= 1'b1;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn && state == REFILL) begin
      tag_mem[miss_idx] <= miss_tag;
      for (int k = 0; k < 4; k++) data_mem[miss_idx][k] <= lfb[k];
    end
  end

  // Forwarded miss data is read straight out of the LFB the cycle after it lands.
  assign icu_ifu_data_valid_ic2 = !resetn && (hit_r || fwd_r);
  assign icu_ifu_data_ic2       = resetn ? 64'h0 :
                                  hit_r  ? hit_data :
                                  fwd_r  ? lfb[miss_off] : 64'h0;

endmodule

// File: tb/tb_top.sv
// Directed-vector bench for the instruction cache top: reset, cold/warm fetches,
// blocked requests during a miss, set conflicts and reset aborting a fill.
module tb_top;

  localparam int NSETS = 64;
  localparam logic [63:0] D_B = 64'hBBBBBBBBBBBBBBBB;
  localparam logic [63:0] D_C = 64'hCCCCCCCCCCCCCCCC;
  localparam logic [63:0] D_D = 64'hDDDDDDDDDDDDDDDD;
  localparam logic [63:0] D_E = 64'hEEEEEEEEEEEEEEEE;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req;
  logic [31:3] addr;
  logic        ack;
  logic        dv;
  logic [63:0] data;

  int n_vec  = 0;
  int n_fail = 0;
  int dv_cnt = 0;
  int breq_cnt = 0;
  int zero_err = 0;
  logic [63:0] last_dv;

  top #(.NSETS(NSETS), .BIU_ACK_DLY(1)) dut (
    .clk                    (clk),
    .resetn                 (resetn),
    .ifu_icu_req_ic1        (req),
    .ifu_icu_addr_ic1       (addr),
    .icu_ifu_ack_ic1        (ack),
    .icu_ifu_data_valid_ic2 (dv),
    .icu_ifu_data_ic2       (data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dv) begin
      dv_cnt++;
      last_dv = data;
    end
    if (dut.icu_biu_req) breq_cnt++;
    if (!dv && data != 64'h0) zero_err++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One fetch: hold req until acked, then check the single returned doubleword.
  task automatic do_req(input logic [31:3] a, input logic [63:0] exp, input bit exp_hit,
                        input bit now, input string tag);
    int n;
    int p0;
    int b0;
    p0 = dv_cnt;
    b0 = breq_cnt;
    if (!now) @(negedge clk);
    req = 1'b1;
    addr = a;
    #1;
    n = 0;
    while (!ack && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk({tag, "_ack"}, ack, 1'b1);
    @(negedge clk);
    req = 1'b0;
    addr = '0;
    #1;
    if (exp_hit) begin
      chk({tag, "_hit_dv"}, dv, 1'b1);
      chk({tag, "_hit_data"}, data, exp);
    end else begin
      n = 0;
      while (!dv && n < 100) begin
        @(negedge clk); #1;
        n++;
      end
      chk({tag, "_miss_dv"}, dv, 1'b1);
      chk({tag, "_miss_data"}, data, exp);
    end
    repeat (12) @(negedge clk);
    #1;
    chk({tag, "_pulses"}, 64'(dv_cnt - p0), 64'd1);
    chk({tag, "_biu_req"}, 64'(breq_cnt > b0), 64'(!exp_hit));
  endtask

  initial begin
    int n;
    int p0;
    resetn = 1'b1;
    req = 1'b0;
    addr = '0;

    // Reset held three cycles with no request: everything quiet.
    repeat (3) begin
      @(negedge clk); #1;
      chk("rst_ack", ack, 1'b0);
      chk("rst_dv", dv, 1'b0);
      chk("rst_data", data, 64'h0);
      chk("rst_biu_req", dut.icu_biu_req, 1'b0);
    end
    @(negedge clk);
    req = 1'b1;
    addr = 29'h2021;
    #1;
    chk("rst_ack_gated", ack, 1'b0);
    chk("rst_no_biu", 64'(breq_cnt), 64'd0);

    // Release and request on the very first edge.
    @(negedge clk);
    resetn = 1'b0;
    do_req(29'h2021, D_C, 1'b0, 1'b1, "cold_2021");

    do_req(29'h2021, D_C, 1'b1, 1'b0, "hit_2021");
    do_req(29'h2023, D_E, 1'b1, 1'b0, "hit_2023");
    do_req(29'h2020, D_B, 1'b1, 1'b0, "hit_2020");
    do_req(29'h2022, D_D, 1'b1, 1'b0, "hit_2022");

    // Request held during an outstanding miss is only acked once back in IDLE.
    p0 = dv_cnt;
    @(negedge clk);
    req = 1'b1;
    addr = 29'h2000;
    #1;
    chk("hold_ack_first", ack, 1'b1);
    @(negedge clk);
    addr = 29'h2040;
    #1;
    n = 0;
    while (!ack && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk("hold_wait_cycles", 64'(n), 64'd7);
    chk("hold_first_data", last_dv, D_B);
    @(negedge clk);
    req = 1'b0;
    addr = '0;
    #1;
    n = 0;
    while (!dv && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    chk("hold_second_data", data, D_B);
    repeat (12) @(negedge clk);
    #1;
    chk("hold_pulses", 64'(dv_cnt - p0), 64'd2);
    do_req(29'h2040, D_B, 1'b1, 1'b0, "hit_2040");

    // Same set, different tag: evicts and refills each time.
    do_req(29'h2021 + NSETS * 4, D_C, 1'b0, 1'b0, "conf_miss_a");
    do_req(29'h2121, D_C, 1'b1, 1'b0, "conf_hit_a");
    do_req(29'h2021, D_C, 1'b0, 1'b0, "conf_miss_b");

    // Reset two cycles after a miss ack aborts the fill and clears valids.
    p0 = dv_cnt;
    @(negedge clk);
    req = 1'b1;
    addr = 29'h2061;
    #1;
    chk("abort_ack", ack, 1'b1);
    @(negedge clk);
    req = 1'b0;
    addr = '0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("abort_no_pulse", 64'(dv_cnt - p0), 64'd0);
    chk("abort_biu_idle", 64'(dut.biu_icu_data_valid), 64'd0);
    do_req(29'h2021, D_C, 1'b0, 1'b0, "post_rst_2021");
    do_req(29'h2061, D_C, 1'b0, 1'b0, "post_rst_2061");

    chk("data_zero_when_idle", 64'(zero_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
